// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares the single DATA_W-bit data-RAM port between the processor's vector
//   load/store path (CPU) and an external host/loader (HOST). Grants are
//   combinational and the RAM controls are muxed from the winner. Reads are
//   tagged with their owner in a RD_LAT-deep return pipeline so that each
//   return is steered to its issuer. host_lock fences the CPU out (after any
//   CPU reads already in flight have drained) for bulk load/readback.
//
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   cpu_*  (rden/wren/address/byteena/writedata -> gnt/rvalid/readdata)
//   host_* (same set for the host)
//   host_lock -> locked               exclusive host ownership request/status
//   ram_*                             RAM macro port (readdata is RD_LAT late)
module vram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 256,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rden,
  input  logic                  cpu_wren,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic [DATA_W/8-1:0]   cpu_byteena,
  input  logic [DATA_W-1:0]     cpu_writedata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_readdata,
  input  logic                  host_rden,
  input  logic                  host_wren,
  input  logic [ADDR_W-1:0]     host_address,
  input  logic [DATA_W/8-1:0]   host_byteena,
  input  logic [DATA_W-1:0]     host_writedata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_W-1:0]     host_readdata,
  input  logic                  host_lock,
  output logic                  locked,
  output logic                  ram_rden,
  output logic                  ram_wren,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteena,
  output logic [DATA_W-1:0]     ram_writedata,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef enum logic [1:0] {
    ST_SHARED = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [RD_LAT-1:0] rv_valid_q, rv_valid_d;
  logic [RD_LAT-1:0] rv_owner_q, rv_owner_d;

  logic cpu_req;
  logic host_req;
  logic rd_issue;
  logic cpu_rd_pending;

  assign cpu_req  = cpu_rden | cpu_wren;
  assign host_req = host_rden | host_wren;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SHARED;
      last_gnt_q <= OWN_HOST;
      rv_valid_q <= '0;
      rv_owner_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rv_valid_q <= rv_valid_d;
      rv_owner_q <= rv_owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    // A CPU read sitting in the last stage is being returned this cycle and
    // no longer counts as outstanding; only earlier stages and a read issued
    // right now keep the drain open.
    cpu_rd_pending = cpu_gnt & rd_issue;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      cpu_rd_pending = cpu_rd_pending | (rv_valid_q[i] & (rv_owner_q[i] == OWN_CPU));
    end

    state_d = state_q;
    case (state_q)
      ST_SHARED: if (host_lock) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!host_lock)          state_d = ST_SHARED;
        else if (!cpu_rd_pending) state_d = ST_LOCKED;
      end
      ST_LOCKED: if (!host_lock) state_d = ST_SHARED;
      default:   state_d = ST_SHARED;
    endcase

    last_gnt_d = last_gnt_q;
    if (cpu_gnt)       last_gnt_d = OWN_CPU;
    else if (host_gnt) last_gnt_d = OWN_HOST;

    rv_valid_d[0] = rd_issue;
    rv_owner_d[0] = host_gnt;
    for (int i = 1; i < RD_LAT; i++) begin
      rv_valid_d[i] = rv_valid_q[i-1];
      rv_owner_d[i] = rv_owner_q[i-1];
    end
  end

  // Output logic
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    // Grants are forced low while reset is held, regardless of requests.
    if (!reset) begin
      case (state_q)
        ST_SHARED: begin
          if (cpu_req && host_req) begin
            cpu_gnt  = (last_gnt_q == OWN_HOST);
            host_gnt = (last_gnt_q == OWN_CPU);
          end else begin
            cpu_gnt  = cpu_req;
            host_gnt = host_req;
          end
        end
        default: host_gnt = host_req;
      endcase
    end

    locked   = (state_q == ST_LOCKED);

    ram_rden = (cpu_gnt & cpu_rden) | (host_gnt & host_rden);
    ram_wren = (cpu_gnt & cpu_wren) | (host_gnt & host_wren);
    // rden together with wren is a write only, so it never enters the pipeline.
    rd_issue = ram_rden & ~ram_wren;

    ram_address   = host_gnt ? host_address   : cpu_address;
    ram_byteena   = host_gnt ? host_byteena   : cpu_byteena;
    ram_writedata = host_gnt ? host_writedata : cpu_writedata;
  end

  assign cpu_rvalid    = rv_valid_q[RD_LAT-1] & (rv_owner_q[RD_LAT-1] == OWN_CPU);
  assign host_rvalid   = rv_valid_q[RD_LAT-1] & (rv_owner_q[RD_LAT-1] == OWN_HOST);
  assign cpu_readdata  = ram_readdata;
  assign host_readdata = ram_readdata;

endmodule
